// File: rtl/uart_cipher_pkg.sv
// Shared constants for the UART stream cipher: keystream modes, FSM encoding, default taps.
package uart_cipher_pkg;

    localparam logic MODE_STATIC  = 1'b0;
    localparam logic MODE_ROLLING = 1'b1;

    localparam logic [0:0] ST_UNSYNC = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

endpackage

// File: rtl/cipher_lfsr.sv
// Galois LFSR with synchronous seed load and single-step advance; resets to all ones.
module cipher_lfsr
    import uart_cipher_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEFAULT_TAPS),
    parameter int               OUT_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [WIDTH-1:0]     seed_i,
    input  logic                 advance_i,
    output logic [OUT_WIDTH-1:0] state_o
);

    logic [WIDTH-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (advance_i) begin
            state_d = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '1;
        end else begin
            state_q <= state_d;
        end
    end

    // Consumers that only need the keystream byte take the low bits.
    assign state_o = state_q[OUT_WIDTH-1:0];

endmodule

// File: rtl/uart_stream_cipher.sv
// Registered XOR stream cipher with valid/ready handshake, static or rolling LFSR keystream.
//
// state  | meaning
// UNSYNC | no keystream alignment yet; input is refused
// RUN    | key/mode latched; words are accepted when the output register is free
module uart_stream_cipher
    import uart_cipher_pkg::*;
#(
    parameter int                   DATA_WIDTH = 8,
    parameter int                   KEY_WIDTH  = 16,
    parameter logic [KEY_WIDTH-1:0] TAPS       = KEY_WIDTH'(DEFAULT_TAPS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [KEY_WIDTH-1:0]  key_i,
    input  logic                  mode_i,
    input  logic                  resync_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  synced_o,
    output logic [15:0]           word_count_o
);

    // Static mode only ever reads key bits below min(DATA_WIDTH, KEY_WIDTH).
    localparam int KL_W = (DATA_WIDTH < KEY_WIDTH) ? DATA_WIDTH : KEY_WIDTH;

    logic [0:0]            state_q, state_d;
    logic [KL_W-1:0]       key_lat_q, key_lat_d;
    logic                  mode_lat_q, mode_lat_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [15:0]           word_count_q, word_count_d;

    logic [DATA_WIDTH-1:0] ks, ks_static, ks_roll;
    logic [KEY_WIDTH-1:0]  seed;
    logic                  accept;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_static_ks
        assign ks_static[i] = key_lat_q[i % KEY_WIDTH];
    end

    cipher_lfsr #(
        .WIDTH     (KEY_WIDTH),
        .TAPS      (TAPS),
        .OUT_WIDTH (DATA_WIDTH)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (resync_i),
        .seed_i    (seed),
        .advance_i (accept && (mode_lat_q == MODE_ROLLING)),
        .state_o   (ks_roll)
    );

    // An all-zero seed would lock the LFSR at zero forever.
    assign seed = (key_i == '0) ? '1 : key_i;
    assign ks   = (mode_lat_q == MODE_ROLLING) ? ks_roll : ks_static;

    assign in_ready_o = (state_q == ST_RUN) && !resync_i && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d      = state_q;
        key_lat_d    = key_lat_q;
        mode_lat_d   = mode_lat_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        word_count_d = word_count_q;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            out_data_d   = in_data_i ^ ks;
            out_valid_d  = 1'b1;
            word_count_d = word_count_q + 16'd1;
        end
        if (resync_i) begin
            state_d      = ST_RUN;
            key_lat_d    = key_i[KL_W-1:0];
            mode_lat_d   = mode_i;
            word_count_d = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_UNSYNC;
            key_lat_q    <= '0;
            mode_lat_q   <= MODE_STATIC;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            word_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            key_lat_q    <= key_lat_d;
            mode_lat_q   <= mode_lat_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            word_count_q <= word_count_d;
        end
    end

    assign out_data_o   = out_data_q;
    assign out_valid_o  = out_valid_q;
    assign synced_o     = (state_q == ST_RUN);
    assign word_count_o = word_count_q;

endmodule

// File: tb/tb_uart_stream_cipher.sv
// Bench for uart_stream_cipher: directed mode/handshake steps and a chained TX->RX round trip.
module tb_uart_stream_cipher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] key;
    logic        mode;
    logic        tx_resync, rx_resync;
    logic [7:0]  tx_in_data;
    logic        tx_in_valid;
    logic        tb_out_ready, rx_out_ready, chain;

    logic        tx_in_ready, tx_out_valid, tx_out_ready, tx_synced;
    logic [7:0]  tx_out_data;
    logic [15:0] tx_word_count;
    logic        rx_in_valid, rx_in_ready, rx_out_valid, rx_synced;
    logic [7:0]  rx_out_data;
    logic [15:0] rx_word_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign tx_out_ready = chain ? rx_in_ready : tb_out_ready;
    assign rx_in_valid  = chain && tx_out_valid;

    uart_stream_cipher u_tx (
        .clk(clk), .rst_n(rst_n), .key_i(key), .mode_i(mode), .resync_i(tx_resync),
        .in_data_i(tx_in_data), .in_valid_i(tx_in_valid), .in_ready_o(tx_in_ready),
        .out_data_o(tx_out_data), .out_valid_o(tx_out_valid), .out_ready_i(tx_out_ready),
        .synced_o(tx_synced), .word_count_o(tx_word_count)
    );

    uart_stream_cipher u_rx (
        .clk(clk), .rst_n(rst_n), .key_i(key), .mode_i(mode), .resync_i(rx_resync),
        .in_data_i(tx_out_data), .in_valid_i(rx_in_valid), .in_ready_o(rx_in_ready),
        .out_data_o(rx_out_data), .out_valid_o(rx_out_valid), .out_ready_i(rx_out_ready),
        .synced_o(rx_synced), .word_count_o(rx_word_count)
    );

    // Reference keystream: one Galois step of the 16-bit register with mask 0xB400.
    function automatic logic [15:0] galois(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resync_tx(input logic [15:0] k, input logic m);
        key = k; mode = m; tx_resync = 1'b1;
        step();
        tx_resync = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d);
        int n = 0;
        tx_in_data = d; tx_in_valid = 1'b1;
        #1;
        while (!tx_in_ready && n < 20) begin
            step();
            n++;
        end
        check("send_timeout", 32'(n < 20), 32'd1);
        step();
        tx_in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] model;
        logic [7:0]  d;
        logic [7:0]  sent_q[$];
        logic [7:0]  exp_w;
        int          sent, recv, cyc;

        rst_n = 1'b0; key = '0; mode = 1'b0; tx_resync = 1'b0; rx_resync = 1'b0;
        tx_in_data = '0; tx_in_valid = 1'b1; tb_out_ready = 1'b1; rx_out_ready = 1'b0; chain = 1'b0;
        #1;
        check("rst_out_valid", 32'(tx_out_valid), 32'd0);
        check("rst_out_data", 32'(tx_out_data), 32'd0);
        check("rst_word_count", 32'(tx_word_count), 32'd0);
        check("rst_synced", 32'(tx_synced), 32'd0);
        check("rst_in_ready", 32'(tx_in_ready), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("unsync_in_ready", 32'(tx_in_ready), 32'd0);
        check("unsync_no_accept", 32'(tx_out_valid), 32'd0);
        tx_in_valid = 1'b0;

        // Static key: 0xA5 ^ 0x05 = 0xA0; later key changes without resync are ignored.
        tx_in_valid = 1'b1; tx_resync = 1'b1; key = 16'h0005; mode = 1'b0;
        #1;
        check("resync_cycle_in_ready", 32'(tx_in_ready), 32'd0);
        step();
        tx_resync = 1'b0; tx_in_valid = 1'b0;
        check("synced", 32'(tx_synced), 32'd1);
        check("resync_no_accept", 32'(tx_out_valid), 32'd0);
        send_word(8'hA5);
        check("static_data", 32'(tx_out_data), 32'hA0);
        check("static_valid", 32'(tx_out_valid), 32'd1);
        check("static_count", 32'(tx_word_count), 32'd1);
        key = 16'hFFFF; mode = 1'b1;
        step();
        check("drain_clears_valid", 32'(tx_out_valid), 32'd0);
        send_word(8'h0F);
        check("key_change_ignored", 32'(tx_out_data), 32'h0A);
        check("static_count2", 32'(tx_word_count), 32'd2);

        // Rolling mode from the spec seed.
        resync_tx(16'hACE1, 1'b1);
        check("resync_clears_count", 32'(tx_word_count), 32'd0);
        send_word(8'h00);
        check("roll_data0", 32'(tx_out_data), 32'hE1);
        send_word(8'h00);
        check("roll_data1", 32'(tx_out_data), 32'h70);
        check("roll_count", 32'(tx_word_count), 32'd2);

        resync_tx(16'h0000, 1'b1);
        send_word(8'h00);
        check("zero_seed", 32'(tx_out_data), 32'hFF);

        // Backpressure: stalled output must freeze and must not advance the keystream.
        resync_tx(16'hACE1, 1'b1);
        model = 16'hACE1;
        tb_out_ready = 1'b0;
        send_word(8'h00);
        check("bp_first", 32'(tx_out_data), 32'(model[7:0]));
        model = galois(model);
        for (int i = 0; i < 3; i++) begin
            tx_in_valid = 1'b1; tx_in_data = 8'($urandom);
            #1;
            check("bp_in_ready", 32'(tx_in_ready), 32'd0);
            check("bp_data_hold", 32'(tx_out_data), 32'hE1);
            check("bp_valid_hold", 32'(tx_out_valid), 32'd1);
            step();
        end
        tx_in_valid = 1'b0;
        tb_out_ready = 1'b1;
        send_word(8'h00);
        check("bp_resume", 32'(tx_out_data), 32'h70);
        model = galois(model);
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            send_word(d);
            check("roll_random", 32'(tx_out_data), 32'(d ^ model[7:0]));
            model = galois(model);
        end
        check("roll_count6", 32'(tx_word_count), 32'd6);
        step();

        // Round trip: TX encrypts, RX decrypts, both aligned by a shared resync.
        chain = 1'b1;
        key = 16'h1234; mode = 1'b1; tx_resync = 1'b1; rx_resync = 1'b1;
        step();
        tx_resync = 1'b0; rx_resync = 1'b0;
        sent = 0; recv = 0; cyc = 0;
        while (recv < 256 && cyc < 5000) begin
            tx_in_valid  = (sent < 256) && ($urandom_range(3) != 0);
            if (tx_in_valid) tx_in_data = 8'($urandom);
            rx_out_ready = ($urandom_range(3) != 0);
            #1;
            if (rx_out_valid && rx_out_ready) begin
                exp_w = (sent_q.size() > 0) ? sent_q.pop_front() : 8'hxx;
                check("roundtrip_word", 32'(rx_out_data), 32'(exp_w));
                recv++;
            end
            if (tx_in_valid && tx_in_ready) begin
                sent_q.push_back(tx_in_data);
                sent++;
            end
            step();
            cyc++;
        end
        tx_in_valid = 1'b0;
        check("roundtrip_complete", 32'(recv), 32'd256);
        check("rx_count", 32'(rx_word_count), 32'd256);

        // Reset with a word pending, then confirm input stays refused until resync.
        chain = 1'b0; tb_out_ready = 1'b0;
        resync_tx(16'hACE1, 1'b1);
        send_word(8'h55);
        check("pending_before_reset", 32'(tx_out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_drops_word", 32'(tx_out_valid), 32'd0);
        check("reset_synced", 32'(tx_synced), 32'd0);
        step();
        rst_n = 1'b1; tb_out_ready = 1'b1;
        tx_in_valid = 1'b1; tx_in_data = 8'h33;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("post_reset_in_ready", 32'(tx_in_ready), 32'd0);
            step();
        end
        check("post_reset_ignored", 32'(tx_out_valid), 32'd0);
        check("post_reset_count", 32'(tx_word_count), 32'd0);
        tx_in_valid = 1'b0;
        resync_tx(16'hACE1, 1'b1);
        send_word(8'h00);
        check("post_reset_reseed", 32'(tx_out_data), 32'hE1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
